mem_req_engine: RTL and testbench

- Bus master that sits directly upstream of the endpoint word memory.
- Consumes a 32-bit request flit stream from the endpoint RX path, decodes read/write burst requests and drives bus_protocol_if-style master signals (addr/wen/ren/wdata/strobe, honouring request_stall).
- Returns write acks and read data as a 32-bit response flit stream to the TX path.

---
 rtl/chiplet_types_pkg.sv | 37 +++
 rtl/mem_resp_reg.sv | 37 +++
 rtl/mem_req_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_req_engine.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chiplet_types_pkg.sv
// Shared types for the chiplet endpoint memory path.
// Holds the bus word type, request opcodes, response codes, the request
// header layout and a helper that builds a response flit.
package chiplet_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    MEM_RD = 4'h1,
    MEM_WR = 4'h2
  } mem_op_t;

  localparam logic [3:0] RESP_RD   = 4'hA;
  localparam logic [3:0] RESP_WACK = 4'hB;
  localparam logic [3:0] RESP_ERR  = 4'hE;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  strobe;
    logic [7:0]  len_m1;
    logic [15:0] rsvd;
  } mem_req_hdr_t;

  // Response flits reuse the header layout: the response code sits in the
  // op slot and the second nibble carries the offending op for errors.
  function automatic word_t make_resp(input logic [3:0] code,
                                      input logic [3:0] op,
                                      input logic [7:0] len_m1);
    mem_req_hdr_t h;
    h.op     = code;
    h.strobe = op;
    h.len_m1 = len_m1;
    h.rsvd   = '0;
    return word_t'(h);
  endfunction

endpackage

// File: rtl/mem_resp_reg.sv
// One-entry registered output stage for the response flit stream.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load, load_data   write a new flit; only legal while space is high
//   tx_ready          downstream consumes the held flit
//   tx_valid, tx_data registered flit, held stable until consumed
//   space             register is empty or being emptied this cycle
module mem_resp_reg
  import chiplet_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  word_t load_data,
  input  logic  tx_ready,
  output logic  tx_valid,
  output word_t tx_data,
  output logic  space
);

  assign space = !tx_valid || tx_ready;

  // Loading while the current flit drains gives one flit per cycle with
  // tx_ready held high; the data word is left in place once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_data;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_req_engine.sv
// Bus master between the endpoint request/response flit streams and the
// endpoint word memory. Decodes read/write burst requests, drives the
// addr/wen/ren/wdata/strobe bus honouring request_stall, and returns write
// acks, read data or error responses.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   rx_valid, rx_data, rx_ready request flit stream in
//   tx_valid, tx_data, tx_ready response flit stream out
//   addr, wen, ren, wdata, strobe, rdata, request_stall  memory bus
//   busy                        engine not idle
//   err_count                   saturating count of rejected requests
// Build option: define MEM_REQ_BOUNDS_CHECK_EN to reject bursts running
// past NUM_WORDS (write payload is drained, then an error is returned).
module mem_req_engine
  import chiplet_types_pkg::*;
#(
  parameter int NUM_WORDS = 128,
  parameter int MAX_LEN   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready,
  output logic [31:0] addr,
  output logic        wen,
  output logic        ren,
  output logic [31:0] wdata,
  output logic [3:0]  strobe,
  input  logic [31:0] rdata,
  input  logic        request_stall,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

`ifdef MEM_REQ_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WR    = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  logic [2:0]       state;
  logic [3:0]       op_q;
  logic [3:0]       strobe_q;
  logic [7:0]       len_m1_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] remaining;
  logic             wr_pending;
  logic             flit_loaded;
  logic             err_q;

  logic             rx_ready_int;
  logic             rx_fire;
  logic             write_done;
  logic             read_done;
  logic             space;
  logic             load;
  word_t            load_data;
  logic [CNT_W-1:0] len;
  logic [30:0]      end_word;
  logic             op_legal;
  logic             out_of_range;
  logic             last_word;

  assign len          = CNT_W'(len_m1_q) + CNT_W'(1);
  assign op_legal     = (op_q == MEM_RD) || (op_q == MEM_WR);
  assign end_word     = {1'b0, rx_data[31:2]} + 31'(len);
  assign out_of_range = BOUNDS_EN && (end_word > 31'(NUM_WORDS));
  assign last_word    = (remaining == CNT_W'(1));

  assign wen        = (state == S_WR) && wr_pending;
  assign ren        = (state == S_RD) && flit_loaded && space;
  assign write_done = wen && !request_stall;
  assign read_done  = ren && !request_stall;
  assign strobe     = wen ? strobe_q : 4'h0;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign busy       = (state != S_IDLE);
  assign rx_ready   = rx_ready_int && !rst;
  assign rx_fire    = rx_valid && rx_ready;

  // In WR the next payload flit may enter in the same cycle the pending
  // write completes, except after the final word of the burst.
  always_comb begin
    rx_ready_int = 1'b0;
    case (state)
      S_IDLE, S_ADDR, S_DRAIN: rx_ready_int = 1'b1;
      S_WR:    rx_ready_int = !wr_pending || (write_done && !last_word);
      default: rx_ready_int = 1'b0;
    endcase
  end

  // Selects what goes into the response register: the read header before
  // any bus read, read data on each completed read, or the final response.
  always_comb begin
    load      = 1'b0;
    load_data = '0;
    if (state == S_RD && !flit_loaded && space) begin
      load      = 1'b1;
      load_data = make_resp(RESP_RD, 4'h0, len_m1_q);
    end else if (read_done) begin
      load      = 1'b1;
      load_data = rdata;
    end else if (state == S_RESP && !flit_loaded && space) begin
      load      = 1'b1;
      load_data = err_q ? make_resp(RESP_ERR, op_q, len_m1_q)
                        : make_resp(RESP_WACK, 4'h0, len_m1_q);
    end
  end

  // Request FSM. flit_loaded marks that the read header or final response
  // has entered the output register, so RESP only leaves once its own flit
  // is consumed rather than an earlier read data word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= '0;
      strobe_q    <= '0;
      len_m1_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      remaining   <= '0;
      wr_pending  <= 1'b0;
      flit_loaded <= 1'b0;
      err_q       <= 1'b0;
      err_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            op_q     <= rx_data[31:28];
            strobe_q <= rx_data[27:24];
            len_m1_q <= rx_data[23:16];
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            addr_q      <= {rx_data[31:2], 2'b00};
            remaining   <= len;
            flit_loaded <= 1'b0;
            err_q       <= 1'b0;
            if (!op_legal) begin
              err_q     <= 1'b1;
              remaining <= '0;
              state     <= S_RESP;
            end else if (out_of_range) begin
              err_q <= 1'b1;
              state <= (op_q == MEM_WR) ? S_DRAIN : S_RESP;
            end else begin
              state <= (op_q == MEM_WR) ? S_WR : S_RD;
            end
          end
        end
        S_WR: begin
          if (write_done) begin
            addr_q    <= addr_q + 32'd4;
            remaining <= remaining - CNT_W'(1);
          end
          if (rx_fire) begin
            wr_pending <= 1'b1;
            wdata_q    <= rx_data;
          end else if (write_done) begin
            wr_pending <= 1'b0;
          end
          if (write_done && last_word) begin
            state <= S_RESP;
          end
        end
        S_RD: begin
          if (!flit_loaded && space) begin
            flit_loaded <= 1'b1;
          end
          if (read_done) begin
            addr_q    <= addr_q + 32'd4;
            remaining <= remaining - CNT_W'(1);
            if (last_word) begin
              state <= S_IDLE;
            end
          end
        end
        S_RESP: begin
          if (!flit_loaded && space) begin
            flit_loaded <= 1'b1;
            if (err_q && err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end else if (flit_loaded && tx_valid && tx_ready) begin
            state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (rx_fire) begin
            remaining <= remaining - CNT_W'(1);
            if (last_word) begin
              state <= S_RESP;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  mem_resp_reg u_resp_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .space     (space)
  );

endmodule

// File: tb/tb_mem_req_engine.sv
// Directed testbench for mem_req_engine with a 128-word byte-strobed memory
// model on the bus side. Honours MEM_REQ_BOUNDS_CHECK_EN for the bounds test.
module tb_mem_req_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_ready;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready = 1'b1;
  logic [31:0] addr;
  logic        wen;
  logic        ren;
  logic [31:0] wdata;
  logic [3:0]  strobe;
  logic [31:0] rdata;
  logic        request_stall = 1'b0;
  logic        busy;
  logic [7:0]  err_count;

  int total = 0;
  int bad = 0;
  int bus_cycles = 0;
  int both_cycles = 0;
  int stall_cnt = 0;
  logic stall_mode = 1'b0;

  logic [31:0] mem [0:127] = '{default: '0};
  logic [31:0] tx_log [$];
  logic [67:0] wr_log [$];

  always #5 clk = ~clk;

  mem_req_engine dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .addr          (addr),
    .wen           (wen),
    .ren           (ren),
    .wdata         (wdata),
    .strobe        (strobe),
    .rdata         (rdata),
    .request_stall (request_stall),
    .busy          (busy),
    .err_count     (err_count)
  );

  // Memory model: combinational read, byte-strobed write on completion.
  assign rdata = mem[addr[8:2]];

  always @(posedge clk) begin
    if (wen && !request_stall) begin
      for (int b = 0; b < 4; b++) begin
        if (strobe[b]) mem[addr[8:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Observe handshakes and bus activity mid-cycle.
  always @(negedge clk) begin
    if (tx_valid && tx_ready && !rst) tx_log.push_back(tx_data);
    if (wen && !request_stall) wr_log.push_back({addr, wdata, strobe});
    if (wen || ren) bus_cycles++;
    if (wen && ren) both_cycles++;
  end

  // Stall generator: three stalled cycles in front of every bus completion.
  always @(posedge clk) begin
    #2;
    if (stall_mode && (wen || ren)) begin
      if (stall_cnt < 3) begin
        request_stall = 1'b1;
        stall_cnt++;
      end else begin
        request_stall = 1'b0;
        stall_cnt = 0;
      end
    end else begin
      request_stall = 1'b0;
      stall_cnt = 0;
    end
  end

  task automatic send_flit(input logic [31:0] d);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = d;
    @(negedge clk);
    while (!rx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      total++; bad++;
      $display("[TB] FAIL rx_accept_timeout: got rx_ready=%b expected 1 for flit %h", rx_ready, d);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic wait_tx(input int count);
    int n = 0;
    while (tx_log.size() < count && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (tx_log.size() < count) begin
      total++; bad++;
      $display("[TB] FAIL tx_timeout: got %0d flits expected %0d", tx_log.size(), count);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || tx_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy || tx_valid) begin
      total++; bad++;
      $display("[TB] FAIL idle_timeout: got busy=%b tx_valid=%b expected 0", busy, tx_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rx_ready, tx_valid, wen, ren, busy} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000", {rx_ready, tx_valid, wen, ren, busy});
    end
    total++;
    if ({tx_data, addr, wdata, strobe, err_count} !== 108'b0) begin
      bad++;
      $display("[TB] FAIL reset_data: got %h %h %h %h %h expected all zero", tx_data, addr, wdata, strobe, err_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_after_reset: got rx_ready=%b busy=%b expected 1 0", rx_ready, busy);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] exp_addr [3] = '{32'h10, 32'h14, 32'h18};
    logic [31:0] exp_data [3] = '{32'h11, 32'h22, 32'h33};
    logic [31:0] exp_rd   [4] = '{32'hA002_0000, 32'h11, 32'h22, 32'h33};
    logic [67:0] w;
    tx_log.delete();
    wr_log.delete();
    send_flit(32'h2F02_0000);
    send_flit(32'h0000_0010);
    for (int i = 0; i < 3; i++) send_flit(exp_data[i]);
    wait_tx(1);
    total++;
    if (wr_log.size() != 3) begin
      bad++;
      $display("[TB] FAIL wr_count: got %0d expected 3", wr_log.size());
    end
    for (int i = 0; i < 3; i++) begin
      w = (i < wr_log.size()) ? wr_log[i] : '0;
      total++;
      if (w !== {exp_addr[i], exp_data[i], 4'hF}) begin
        bad++;
        $display("[TB] FAIL wr_word%0d: got %h expected %h", i, w, {exp_addr[i], exp_data[i], 4'hF});
      end
    end
    total++;
    if (tx_log.size() < 1 || tx_log[0] !== 32'hB002_0000) begin
      bad++;
      $display("[TB] FAIL wr_ack: got %h expected b0020000", (tx_log.size() > 0) ? tx_log[0] : 32'hx);
    end
    wait_idle();
    tx_log.delete();
    send_flit(32'h1002_0000);
    send_flit(32'h0000_0010);
    wait_tx(4);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= tx_log.size() || tx_log[i] !== exp_rd[i]) begin
        bad++;
        $display("[TB] FAIL rd_flit%0d: got %h expected %h", i, (i < tx_log.size()) ? tx_log[i] : 32'hx, exp_rd[i]);
      end
    end
  endtask

  task automatic test_partial_strobe();
    logic [67:0] w;
    tx_log.delete();
    wr_log.delete();
    send_flit(32'h2300_0000);
    send_flit(32'h0000_0040);
    send_flit(32'hDEAD_BEEF);
    wait_tx(1);
    wait_idle();
    w = (wr_log.size() > 0) ? wr_log[0] : '0;
    total++;
    if (w !== {32'h40, 32'hDEAD_BEEF, 4'h3}) begin
      bad++;
      $display("[TB] FAIL strobe_write: got %h expected %h", w, {32'h40, 32'hDEAD_BEEF, 4'h3});
    end
    total++;
    if (tx_log.size() < 1 || tx_log[0] !== 32'hB000_0000) begin
      bad++;
      $display("[TB] FAIL strobe_ack: got %h expected b0000000", (tx_log.size() > 0) ? tx_log[0] : 32'hx);
    end
    tx_log.delete();
    send_flit(32'h1000_0000);
    send_flit(32'h0000_0040);
    wait_tx(2);
    wait_idle();
    total++;
    if (tx_log.size() < 2 || tx_log[1] !== 32'h0000_BEEF) begin
      bad++;
      $display("[TB] FAIL strobe_readback: got %h expected 0000beef", (tx_log.size() > 1) ? tx_log[1] : 32'hx);
    end
  endtask

  task automatic test_stall_backpressure();
    logic [31:0] exp_rd [5] = '{32'hA003_0000, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
    logic [31:0] prev_addr = '0;
    logic        prev_stalled = 1'b0;
    logic [67:0] w;
    int          cyc = 0;
    stall_mode = 1'b1;
    tx_log.delete();
    wr_log.delete();
    send_flit(32'h2F03_0000);
    send_flit(32'h0000_0060);
    for (int i = 0; i < 4; i++) send_flit(32'hA1 + 32'(i));
    wait_tx(1);
    wait_idle();
    total++;
    if (wr_log.size() != 4) begin
      bad++;
      $display("[TB] FAIL stall_wr_count: got %0d expected 4", wr_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      w = (i < wr_log.size()) ? wr_log[i] : '0;
      total++;
      if (w !== {32'h60 + 32'(4 * i), 32'hA1 + 32'(i), 4'hF}) begin
        bad++;
        $display("[TB] FAIL stall_wr%0d: got %h expected %h", i, w, {32'h60 + 32'(4 * i), 32'hA1 + 32'(i), 4'hF});
      end
    end
    tx_log.delete();
    send_flit(32'h1003_0000);
    send_flit(32'h0000_0060);
    while (tx_log.size() < 5 && cyc < 300) begin
      tx_ready = !(cyc >= 6 && cyc < 11);
      @(negedge clk);
      if (prev_stalled) begin
        total++;
        if (addr !== prev_addr) begin
          bad++;
          $display("[TB] FAIL stall_addr_hold: got %h expected %h", addr, prev_addr);
        end
      end
      prev_stalled = ren && request_stall;
      prev_addr    = addr;
      @(posedge clk); #1;
      cyc++;
    end
    tx_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (tx_log.size() != 5) begin
      bad++;
      $display("[TB] FAIL stall_flit_count: got %0d expected 5", tx_log.size());
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= tx_log.size() || tx_log[i] !== exp_rd[i]) begin
        bad++;
        $display("[TB] FAIL stall_rd%0d: got %h expected %h", i, (i < tx_log.size()) ? tx_log[i] : 32'hx, exp_rd[i]);
      end
    end
    total++;
    if (both_cycles != 0) begin
      bad++;
      $display("[TB] FAIL wen_ren_overlap: got %0d cycles expected 0", both_cycles);
    end
    stall_mode = 1'b0;
    wait_idle();
  endtask

  task automatic test_illegal_op();
    int bus_before;
    bus_before = bus_cycles;
    tx_log.delete();
    send_flit(32'h7000_0000);
    send_flit(32'h0000_0000);
    wait_tx(1);
    wait_idle();
    total++;
    if (tx_log.size() < 1 || tx_log[0] !== 32'hE700_0000) begin
      bad++;
      $display("[TB] FAIL illegal_resp: got %h expected e7000000", (tx_log.size() > 0) ? tx_log[0] : 32'hx);
    end
    total++;
    if (err_count !== 8'd1) begin
      bad++;
      $display("[TB] FAIL illegal_err_count: got %0d expected 1", err_count);
    end
    total++;
    if (bus_cycles != bus_before) begin
      bad++;
      $display("[TB] FAIL illegal_bus_idle: got %0d bus cycles expected 0", bus_cycles - bus_before);
    end
  endtask

  task automatic test_bounds();
    int bus_before;
    bus_before = bus_cycles;
    tx_log.delete();
    wr_log.delete();
    send_flit(32'h2F03_0000);
    send_flit(32'h0000_01F8);
    for (int i = 0; i < 4; i++) send_flit(32'hC1 + 32'(i));
    wait_tx(1);
    wait_idle();
`ifdef MEM_REQ_BOUNDS_CHECK_EN
    total++;
    if (tx_log.size() < 1 || tx_log[0] !== 32'hE203_0000) begin
      bad++;
      $display("[TB] FAIL bounds_resp: got %h expected e2030000", (tx_log.size() > 0) ? tx_log[0] : 32'hx);
    end
    total++;
    if (err_count !== 8'd2) begin
      bad++;
      $display("[TB] FAIL bounds_err_count: got %0d expected 2", err_count);
    end
    total++;
    if (bus_cycles != bus_before || wr_log.size() != 0) begin
      bad++;
      $display("[TB] FAIL bounds_no_bus: got %0d bus cycles expected 0", bus_cycles - bus_before);
    end
`else
    total++;
    if (tx_log.size() < 1 || tx_log[0] !== 32'hB003_0000) begin
      bad++;
      $display("[TB] FAIL unbounded_ack: got %h expected b0030000", (tx_log.size() > 0) ? tx_log[0] : 32'hx);
    end
    total++;
    if (wr_log.size() != 4 || wr_log[3][67:36] !== 32'h204) begin
      bad++;
      $display("[TB] FAIL unbounded_writes: got %0d writes expected 4 ending at 204", wr_log.size());
    end
    total++;
    if (err_count !== 8'd1 || bus_cycles == bus_before) begin
      bad++;
      $display("[TB] FAIL unbounded_err_count: got %0d expected 1", err_count);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    logic [67:0] w;
    tx_log.delete();
    wr_log.delete();
    send_flit(32'h2F07_0000);
    send_flit(32'h0000_0100);
    send_flit(32'hD1);
    send_flit(32'hD2);
    @(posedge clk); #1;
    total++;
    if (wr_log.size() != 2) begin
      bad++;
      $display("[TB] FAIL mid_wr_count: got %0d expected 2", wr_log.size());
    end
    rst = 1'b1;
    #1;
    total++;
    if ({rx_ready, tx_valid, wen, ren, busy} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset_ctrl: got %b expected 00000", {rx_ready, tx_valid, wen, ren, busy});
    end
    total++;
    if ({tx_data, addr, wdata, strobe, err_count} !== 108'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset_data: got %h %h %h %h %h expected all zero", tx_data, addr, wdata, strobe, err_count);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (tx_log.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset_no_ack: got %0d flits busy=%b expected 0 0", tx_log.size(), busy);
    end
    wr_log.delete();
    send_flit(32'h2F00_0000);
    send_flit(32'h0000_0020);
    send_flit(32'h55);
    wait_tx(1);
    wait_idle();
    w = (wr_log.size() > 0) ? wr_log[0] : '0;
    total++;
    if (w !== {32'h20, 32'h55, 4'hF}) begin
      bad++;
      $display("[TB] FAIL post_reset_write: got %h expected %h", w, {32'h20, 32'h55, 4'hF});
    end
    total++;
    if (tx_log.size() < 1 || tx_log[0] !== 32'hB000_0000) begin
      bad++;
      $display("[TB] FAIL post_reset_ack: got %h expected b0000000", (tx_log.size() > 0) ? tx_log[0] : 32'hx);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_stall_backpressure();
    test_illegal_op();
    test_bounds();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
